// File: rtl/pc_redirect_ctrl.sv
// Fetch PC owner: advances on accepted fetches, applies redirects with a
// one-cycle flush bubble, and traps permanently on misaligned targets.
module pc_redirect_ctrl #(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
    parameter int unsigned CNT_W        = 16
) (
    input  logic             ip_clk,
    input  logic             ip_rst,
    input  logic             ip_stall,
    input  logic             ip_redirect_valid,
    input  logic [31:0]      ip_redirect_target,
    input  logic             ip_fetch_ready,
    output logic             op_fetch_valid,
    output logic [31:0]      op_fetch_pc,
    output logic [31:0]      op_link_addr,
    output logic             op_flush,
    output logic             op_trap,
    output logic [31:0]      op_trap_addr,
    output logic [CNT_W-1:0] op_redirect_count
);

    typedef enum logic [1:0] {BOOT, RUN, BUBBLE, TRAP} state_e;

    state_e             state_q;
    logic [31:0]        pc_q;
    logic               valid_q;
    logic               flush_q;
    logic               trap_q;
    logic [31:0]        trap_addr_q;
    logic [CNT_W-1:0]   cnt_q;

    logic               fetch_acc;
    logic               tgt_aligned;
    logic [CNT_W-1:0]   cnt_d;

    assign fetch_acc   = valid_q & ip_fetch_ready & ~ip_stall;
    assign tgt_aligned = (ip_redirect_target[1:0] == 2'b00);
    assign cnt_d       = (&cnt_q) ? cnt_q : cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};

    always_ff @(posedge ip_clk) begin
        if (ip_rst) begin
            state_q     <= BOOT;
            pc_q        <= RESET_VECTOR;
            valid_q     <= 1'b0;
            flush_q     <= 1'b0;
            trap_q      <= 1'b0;
            trap_addr_q <= 32'h0;
            cnt_q       <= '0;
        end else if (state_q != TRAP) begin
            // Redirect outranks stall and any same-cycle fetch handshake.
            if (ip_redirect_valid) begin
                valid_q <= 1'b0;
                if (tgt_aligned) begin
                    state_q <= BUBBLE;
                    pc_q    <= ip_redirect_target;
                    flush_q <= 1'b1;
                    cnt_q   <= cnt_d;
                end else begin
                    state_q     <= TRAP;
                    flush_q     <= 1'b0;
                    trap_q      <= 1'b1;
                    trap_addr_q <= ip_redirect_target;
                end
            end else begin
                flush_q <= 1'b0;
                case (state_q)
                    BOOT, BUBBLE: begin
                        state_q <= RUN;
                        valid_q <= 1'b1;
                    end
                    RUN: begin
                        if (fetch_acc) pc_q <= pc_q + 32'd4;
                    end
                    default: ;
                endcase
            end
        end
    end

    assign op_fetch_valid    = valid_q;
    assign op_fetch_pc       = pc_q;
    assign op_link_addr      = pc_q + 32'd4;
    assign op_flush          = flush_q;
    assign op_trap           = trap_q;
    assign op_trap_addr      = trap_addr_q;
    assign op_redirect_count = cnt_q;

endmodule

// File: tb/tb_pc_redirect_ctrl.sv
// Directed table, hand sequences and a randomized run against a cycle-level
// behavioural model; a CNT_W=4 instance shares the stimulus for saturation.
module tb_pc_redirect_ctrl;

    logic        clk = 1'b0;
    logic        rst, stall, rv, rdy;
    logic [31:0] tgt;

    logic        valid, flush, trap, valid4, flush4, trap4;
    logic [31:0] pc, link, taddr, pc4, link4, taddr4;
    logic [15:0] cnt;
    logic [3:0]  cnt4;

    int total = 0;
    int passed = 0;

    always #5 clk = ~clk;

    pc_redirect_ctrl #(.RESET_VECTOR(32'h0), .CNT_W(16)) dut (
        .ip_clk(clk), .ip_rst(rst), .ip_stall(stall), .ip_redirect_valid(rv),
        .ip_redirect_target(tgt), .ip_fetch_ready(rdy), .op_fetch_valid(valid),
        .op_fetch_pc(pc), .op_link_addr(link), .op_flush(flush), .op_trap(trap),
        .op_trap_addr(taddr), .op_redirect_count(cnt)
    );

    pc_redirect_ctrl #(.RESET_VECTOR(32'h0), .CNT_W(4)) dut4 (
        .ip_clk(clk), .ip_rst(rst), .ip_stall(stall), .ip_redirect_valid(rv),
        .ip_redirect_target(tgt), .ip_fetch_ready(rdy), .op_fetch_valid(valid4),
        .op_fetch_pc(pc4), .op_link_addr(link4), .op_flush(flush4), .op_trap(trap4),
        .op_trap_addr(taddr4), .op_redirect_count(cnt4)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    endtask

    // Drive one cycle's inputs, let the edge happen, sample 1 time unit later.
    task automatic cyc(input logic r, input logic s, input logic v,
                       input logic [31:0] t, input logic y);
        rst = r; stall = s; rv = v; tgt = t; rdy = y;
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic r, s, v; logic [31:0] t; logic y;
        logic [31:0] e_pc; logic e_vld, e_fl, e_trap; logic [31:0] e_taddr; int e_cnt;
    } vec_t;

    // Behavioural model: fetch is "live" except for exactly one cycle after
    // reset or an accepted redirect; a misaligned target freezes everything.
    logic [31:0] m_pc, m_taddr;
    logic        m_vld, m_fl, m_trap;
    int          m_cnt, m_cnt4;

    task automatic model_step(input logic r, input logic s, input logic v,
                              input logic [31:0] t, input logic y);
        if (r) begin
            m_pc = 32'h0; m_vld = 0; m_fl = 0; m_trap = 0; m_taddr = 0; m_cnt = 0; m_cnt4 = 0;
        end else if (!m_trap) begin
            if (v && (t % 4 == 0)) begin
                m_pc = t; m_vld = 0; m_fl = 1;
                m_cnt  = (m_cnt  < 65535) ? m_cnt + 1  : m_cnt;
                m_cnt4 = (m_cnt4 < 15)    ? m_cnt4 + 1 : m_cnt4;
            end else if (v) begin
                m_trap = 1; m_taddr = t; m_vld = 0; m_fl = 0;
            end else begin
                m_fl = 0;
                if (m_vld && y && !s) m_pc = m_pc + 32'd4;
                m_vld = 1;
            end
        end
    endtask

    task automatic chk_model(input string tag);
        chk({tag, ".pc"},    pc,    m_pc);
        chk({tag, ".link"},  link,  m_pc + 32'd4);
        chk({tag, ".valid"}, {31'b0, valid}, {31'b0, m_vld});
        chk({tag, ".flush"}, {31'b0, flush}, {31'b0, m_fl});
        chk({tag, ".trap"},  {31'b0, trap},  {31'b0, m_trap});
        chk({tag, ".taddr"}, taddr, m_taddr);
        chk({tag, ".cnt"},   {16'b0, cnt},   m_cnt);
        chk({tag, ".cnt4"},  {28'b0, cnt4},  m_cnt4);
        chk({tag, ".pc4"},   pc4,   m_pc);
    endtask

    vec_t tbl[$];

    initial begin
        rst = 1; stall = 0; rv = 0; tgt = 0; rdy = 0;
        //        r  s  v  tgt           y   pc            vld fl tr taddr    cnt
        tbl.push_back('{1, 0, 0, 32'h0,        1, 32'h0,        0, 0, 0, 32'h0,   0});
        tbl.push_back('{0, 0, 0, 32'h0,        1, 32'h0,        1, 0, 0, 32'h0,   0});
        tbl.push_back('{0, 0, 0, 32'h0,        1, 32'h4,        1, 0, 0, 32'h0,   0});
        tbl.push_back('{0, 0, 0, 32'h0,        1, 32'h8,        1, 0, 0, 32'h0,   0});
        tbl.push_back('{0, 0, 0, 32'h0,        1, 32'hC,        1, 0, 0, 32'h0,   0});
        tbl.push_back('{0, 0, 0, 32'h0,        1, 32'h10,       1, 0, 0, 32'h0,   0});
        tbl.push_back('{0, 0, 0, 32'h0,        0, 32'h10,       1, 0, 0, 32'h0,   0});
        tbl.push_back('{0, 0, 0, 32'h0,        0, 32'h10,       1, 0, 0, 32'h0,   0});
        tbl.push_back('{0, 0, 0, 32'h0,        0, 32'h10,       1, 0, 0, 32'h0,   0});
        tbl.push_back('{0, 0, 0, 32'h0,        1, 32'h14,       1, 0, 0, 32'h0,   0});
        tbl.push_back('{0, 1, 1, 32'h200,      1, 32'h200,      0, 1, 0, 32'h0,   1});
        tbl.push_back('{0, 0, 0, 32'h0,        1, 32'h200,      1, 0, 0, 32'h0,   1});
        tbl.push_back('{0, 0, 0, 32'h0,        1, 32'h204,      1, 0, 0, 32'h0,   1});
        tbl.push_back('{0, 0, 1, 32'h100,      1, 32'h100,      0, 1, 0, 32'h0,   2});
        tbl.push_back('{0, 0, 1, 32'h300,      1, 32'h300,      0, 1, 0, 32'h0,   3});
        tbl.push_back('{0, 0, 0, 32'h0,        1, 32'h300,      1, 0, 0, 32'h0,   3});
        tbl.push_back('{0, 0, 1, 32'hFFFFFFFC, 1, 32'hFFFFFFFC, 0, 1, 0, 32'h0,   4});
        tbl.push_back('{0, 0, 0, 32'h0,        1, 32'hFFFFFFFC, 1, 0, 0, 32'h0,   4});
        tbl.push_back('{0, 0, 0, 32'h0,        1, 32'h0,        1, 0, 0, 32'h0,   4});
        tbl.push_back('{0, 0, 1, 32'h202,      1, 32'h0,        0, 0, 1, 32'h202, 4});
        tbl.push_back('{0, 0, 1, 32'h400,      1, 32'h0,        0, 0, 1, 32'h202, 4});
        tbl.push_back('{0, 0, 0, 32'h0,        1, 32'h0,        0, 0, 1, 32'h202, 4});
        tbl.push_back('{1, 0, 0, 32'h0,        1, 32'h0,        0, 0, 0, 32'h0,   0});
        tbl.push_back('{0, 0, 0, 32'h0,        1, 32'h0,        1, 0, 0, 32'h0,   0});

        foreach (tbl[i]) begin
            cyc(tbl[i].r, tbl[i].s, tbl[i].v, tbl[i].t, tbl[i].y);
            chk($sformatf("tbl%0d.pc", i),    pc,    tbl[i].e_pc);
            chk($sformatf("tbl%0d.link", i),  link,  tbl[i].e_pc + 32'd4);
            chk($sformatf("tbl%0d.valid", i), {31'b0, valid}, {31'b0, tbl[i].e_vld});
            chk($sformatf("tbl%0d.flush", i), {31'b0, flush}, {31'b0, tbl[i].e_fl});
            chk($sformatf("tbl%0d.trap", i),  {31'b0, trap},  {31'b0, tbl[i].e_trap});
            chk($sformatf("tbl%0d.taddr", i), taddr, tbl[i].e_taddr);
            chk($sformatf("tbl%0d.cnt", i),   {16'b0, cnt},   tbl[i].e_cnt);
            chk($sformatf("tbl%0d.cnt4", i),  {28'b0, cnt4},  tbl[i].e_cnt);
        end

        // Saturation: 17 back-to-back redirects, the 4-bit counter sticks at 0xF.
        cyc(1, 0, 0, 32'h0, 1);
        for (int i = 0; i < 17; i++) begin
            cyc(0, 0, 1, 32'h1000 + 32'(i) * 32'd8, 1);
            if (i == 14) chk("sat15.cnt4", {28'b0, cnt4}, 32'd15);
        end
        chk("sat.cnt4",  {28'b0, cnt4}, 32'd15);
        chk("sat.cnt16", {16'b0, cnt},  32'd17);
        chk("sat.pc",    pc, 32'h1080);
        chk("sat.flush", {31'b0, flush4}, 32'd1);
        cyc(0, 0, 0, 32'h0, 1);
        chk("sat.valid", {31'b0, valid4}, 32'd1);
        chk("sat.trap4", {31'b0, trap4}, 32'd0);
        chk("sat.link4", link4, 32'h1084);
        chk("sat.taddr4", taddr4, 32'h0);

        // Randomized run against the model.
        model_step(1, 0, 0, 32'h0, 0);
        cyc(1, 0, 0, 32'h0, 0);
        chk_model("rnd_rst");
        for (int i = 0; i < 800; i++) begin
            logic r, s, v, y;
            logic [31:0] t;
            r = ($urandom_range(0, 39) == 0);
            s = ($urandom_range(0, 3) == 0);
            v = ($urandom_range(0, 6) == 0);
            y = ($urandom_range(0, 3) != 0);
            t = $urandom;
            if ($urandom_range(0, 7) != 0) t[1:0] = 2'b00;
            if ($urandom_range(0, 9) == 0) t = 32'hFFFFFFFC;
            model_step(r, s, v, t, y);
            cyc(r, s, v, t, y);
            chk_model($sformatf("rnd%0d", i));
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
